// File: rtl/read_buffer_pkg.sv
// Shared constants for the read buffer: line width, ik/param field offsets,
// FSM state encoding and pipeline tag values.
package read_buffer_pkg;

    localparam int CL = 512;

    localparam int IK_X0_LSB      = 0;
    localparam int IK_X1_LSB      = 64;
    localparam int IK_X2_LSB      = 128;
    localparam int IK_X_W         = 33;
    localparam int IK_INFO_LO_LSB = 192;
    localparam int IK_INFO_HI_LSB = 224;
    localparam int IK_INFO_W      = 7;
    localparam int IK_L2_LSB      = 256;

    localparam int PRM_FWD_LSB     = 0;
    localparam int PRM_MIN_LSB     = 64;
    localparam int PRM_PRIMARY_LSB = 128;
    localparam int PRM_W           = 7;

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    localparam logic [5:0] BUBBLE = 6'b110000;
    localparam logic [5:0] DONE   = 6'b100000;

endpackage

// File: rtl/read_query_extract.sv
// Three-stage base query pipeline: latch request, pick the 2-bit base, register result.
// The owner supplies the selected read's base line through i_line.
module read_query_extract #(
    parameter int RL = 128,
    parameter int NW = 6,
    localparam int POS_W = $clog2(RL)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [NW-1:0]     i_read_num,
    input  logic [POS_W-1:0]  i_pos,
    input  logic [5:0]        i_tag,
    input  logic [NW:0]       i_num_reads,
    output logic [NW-1:0]     o_sel_read_num,
    input  logic [2*RL-1:0]   i_line,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic [5:0]        o_tag
);

    logic             r_s1_valid, r_s1_oor, r_s2_valid;
    logic [NW-1:0]    r_s1_read;
    logic [POS_W-1:0] r_s1_pos;
    logic [5:0]       r_s1_tag, r_s2_tag;
    logic [7:0]       r_s2_data;
    logic             w_oor;
    logic [1:0]       w_base;

    assign w_oor = ({1'b0, i_pos} >= (POS_W+1)'(RL)) | ({1'b0, i_read_num} >= i_num_reads);
    assign w_base = i_line[2*r_s1_pos +: 2];
    assign o_sel_read_num = r_s1_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_oor   <= 1'b0;
            r_s1_read  <= '0;
            r_s1_pos   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 8'hFF;
            r_s2_tag   <= '0;
            o_valid    <= 1'b0;
            o_data     <= 8'hFF;
            o_tag      <= '0;
        end else if (!i_stall) begin
            r_s1_valid <= i_valid;
            r_s1_oor   <= w_oor;
            r_s1_read  <= i_read_num;
            r_s1_pos   <= i_pos;
            r_s1_tag   <= i_tag;
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= r_s1_oor ? 8'hFF : {6'b0, w_base};
            r_s2_tag   <= r_s1_tag;
            o_valid    <= r_s2_valid;
            o_data     <= r_s2_data;
            o_tag      <= r_s2_tag;
        end
    end

endmodule

// File: rtl/read_buffer.sv
// Batch read buffer: loads per-read base/param/ik lines, offers reads one at a
// time to the pipeline and answers random base queries.
module read_buffer #(
    parameter int CL             = read_buffer_pkg::CL,
    parameter int READ_NUM_WIDTH = 6,
    parameter int READ_LINES     = 2,
    localparam int RL    = READ_LINES * CL / 8,
    localparam int POS_W = $clog2(RL)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      batch_start,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic                      load_valid,
    input  logic [CL-1:0]             load_data,
    output logic                      load_ready,
    output logic                      load_done,
    output logic                      new_read_valid,
    input  logic                      new_read_ready,
    output logic [READ_NUM_WIDTH-1:0] new_read_num,
    output logic [63:0]               new_ik_x0,
    output logic [63:0]               new_ik_x1,
    output logic [63:0]               new_ik_x2,
    output logic [63:0]               new_ik_info,
    output logic [6:0]                new_forward_i,
    output logic [6:0]                new_min_intv,
    input  logic                      query_valid,
    input  logic [READ_NUM_WIDTH-1:0] query_read_num,
    input  logic [POS_W-1:0]          query_position,
    input  logic [5:0]                query_tag,
    output logic                      new_read_query_valid,
    output logic [7:0]                new_read_query,
    output logic [5:0]                new_read_query_tag,
    output logic [63:0]               primary,
    output logic [63:0]               L2_0,
    output logic [63:0]               L2_1,
    output logic [63:0]               L2_2,
    output logic [63:0]               L2_3
);
    import read_buffer_pkg::*;

    localparam int NW       = READ_NUM_WIDTH;
    localparam int MAX_READ = 2**NW;
    localparam int BEATS    = READ_LINES + 2;
    localparam int BW       = $clog2(BEATS);

    state_t         r_state;
    logic [NW:0]    r_num, r_ptr;
    logic [NW-1:0]  r_read_idx;
    logic [BW-1:0]  r_beat;

    logic [2*RL-1:0]      r_bases   [MAX_READ];
    logic [IK_X_W-1:0]    r_x0      [MAX_READ];
    logic [IK_X_W-1:0]    r_x1      [MAX_READ];
    logic [IK_X_W-1:0]    r_x2      [MAX_READ];
    logic [IK_INFO_W-1:0] r_info_lo [MAX_READ];
    logic [IK_INFO_W-1:0] r_info_hi [MAX_READ];
    logic [PRM_W-1:0]     r_fwd     [MAX_READ];
    logic [PRM_W-1:0]     r_min     [MAX_READ];

    logic          w_accept, w_last_beat, w_issue, w_unused_data;
    logic [NW:0]   w_clamped;
    logic [CL/4-1:0] w_comp;
    logic [NW-1:0] w_rd, w_sel_read;

    assign w_accept    = load_valid & load_ready & ~batch_start;
    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_clamped   = (batch_size > (NW+1)'(MAX_READ)) ? (NW+1)'(MAX_READ) : batch_size;
    assign w_issue     = new_read_valid & new_read_ready & ~stall;
    assign w_unused_data = ^load_data;

    // Keep only the low two bits of every base byte.
    always_comb begin
        w_comp = '0;
        for (int j = 0; j < CL / 8; j++) begin
            w_comp[2*j +: 2] = load_data[8*j +: 2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_num      <= '0;
            r_ptr      <= '0;
            r_read_idx <= '0;
            r_beat     <= '0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
        end else if (batch_start) begin
            r_num      <= w_clamped;
            r_ptr      <= '0;
            r_read_idx <= '0;
            r_beat     <= '0;
            if (w_clamped == '0) begin
                r_state    <= SERVE;
                load_ready <= 1'b0;
                load_done  <= 1'b1;
            end else begin
                r_state    <= LOAD;
                load_ready <= 1'b1;
                load_done  <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    if ({1'b0, r_read_idx} == r_num - 1'b1) begin
                        r_state    <= SERVE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                    end else begin
                        r_read_idx <= r_read_idx + 1'b1;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (w_issue) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Storage is functionally restarted by batch_start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_beat < BW'(READ_LINES)) begin
                r_bases[r_read_idx][r_beat*(CL/4) +: CL/4] <= w_comp;
            end
            if (r_beat == BW'(READ_LINES)) begin
                r_fwd[r_read_idx] <= load_data[PRM_FWD_LSB +: PRM_W];
                r_min[r_read_idx] <= load_data[PRM_MIN_LSB +: PRM_W];
                if (r_read_idx == '0) begin
                    primary <= load_data[PRM_PRIMARY_LSB +: 64];
                end
            end
            if (w_last_beat) begin
                r_x0[r_read_idx]      <= load_data[IK_X0_LSB +: IK_X_W];
                r_x1[r_read_idx]      <= load_data[IK_X1_LSB +: IK_X_W];
                r_x2[r_read_idx]      <= load_data[IK_X2_LSB +: IK_X_W];
                r_info_lo[r_read_idx] <= load_data[IK_INFO_LO_LSB +: IK_INFO_W];
                r_info_hi[r_read_idx] <= load_data[IK_INFO_HI_LSB +: IK_INFO_W];
                if (r_read_idx == '0) begin
                    L2_0 <= load_data[IK_L2_LSB +: 64];
                    L2_1 <= load_data[IK_L2_LSB + 64 +: 64];
                    L2_2 <= load_data[IK_L2_LSB + 128 +: 64];
                    L2_3 <= load_data[IK_L2_LSB + 192 +: 64];
                end
            end
        end
    end

    assign new_read_valid = (r_state == SERVE) && (r_ptr < r_num);
    assign w_rd           = r_ptr[NW-1:0];
    assign new_read_num   = new_read_valid ? w_rd : '1;
    assign new_ik_x0      = new_read_valid ? 64'(r_x0[w_rd]) : '0;
    assign new_ik_x1      = new_read_valid ? 64'(r_x1[w_rd]) : '0;
    assign new_ik_x2      = new_read_valid ? 64'(r_x2[w_rd]) : '0;
    assign new_ik_info    = new_read_valid ?
                            {25'b0, r_info_hi[w_rd], 25'b0, r_info_lo[w_rd]} : '0;
    assign new_forward_i  = new_read_valid ? r_fwd[w_rd] : '0;
    assign new_min_intv   = new_read_valid ? r_min[w_rd] : '0;

    read_query_extract #(
        .RL (RL),
        .NW (NW)
    ) u_query (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_stall        (stall),
        .i_valid        (query_valid),
        .i_read_num     (query_read_num),
        .i_pos          (query_position),
        .i_tag          (query_tag),
        .i_num_reads    (r_num),
        .o_sel_read_num (w_sel_read),
        .i_line         (r_bases[w_sel_read]),
        .o_valid        (new_read_query_valid),
        .o_data         (new_read_query),
        .o_tag          (new_read_query_tag)
    );

endmodule

// File: tb/tb_read_buffer.sv
// Directed + randomized bench for read_buffer with a line-level reference model.
module tb_read_buffer;

    localparam int CL    = 512;
    localparam int NW    = 6;
    localparam int RLN   = 2;
    localparam int RL    = RLN * CL / 8;
    localparam int POS_W = $clog2(RL);

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            stall = 1'b0;
    logic            batch_start = 1'b0;
    logic [NW:0]     batch_size = '0;
    logic            load_valid = 1'b0;
    logic [CL-1:0]   load_data = '0;
    logic            load_ready, load_done, new_read_valid;
    logic            new_read_ready = 1'b0;
    logic [NW-1:0]   new_read_num;
    logic [63:0]     new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info;
    logic [6:0]      new_forward_i, new_min_intv;
    logic            query_valid = 1'b0;
    logic [NW-1:0]   query_read_num = '0;
    logic [POS_W-1:0] query_position = '0;
    logic [5:0]      query_tag = '0;
    logic            new_read_query_valid;
    logic [7:0]      new_read_query;
    logic [5:0]      new_read_query_tag;
    logic [63:0]     primary, L2_0, L2_1, L2_2, L2_3;

    read_buffer #(
        .CL             (CL),
        .READ_NUM_WIDTH (NW),
        .READ_LINES     (RLN)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .stall                (stall),
        .batch_start          (batch_start),
        .batch_size           (batch_size),
        .load_valid           (load_valid),
        .load_data            (load_data),
        .load_ready           (load_ready),
        .load_done            (load_done),
        .new_read_valid       (new_read_valid),
        .new_read_ready       (new_read_ready),
        .new_read_num         (new_read_num),
        .new_ik_x0            (new_ik_x0),
        .new_ik_x1            (new_ik_x1),
        .new_ik_x2            (new_ik_x2),
        .new_ik_info          (new_ik_info),
        .new_forward_i        (new_forward_i),
        .new_min_intv         (new_min_intv),
        .query_valid          (query_valid),
        .query_read_num       (query_read_num),
        .query_position       (query_position),
        .query_tag            (query_tag),
        .new_read_query_valid (new_read_query_valid),
        .new_read_query       (new_read_query),
        .new_read_query_tag   (new_read_query_tag),
        .primary              (primary),
        .L2_0                 (L2_0),
        .L2_1                 (L2_1),
        .L2_2                 (L2_2),
        .L2_3                 (L2_3)
    );

    always #5 clk = ~clk;

    // Model: every line of the current batch, as presented (base0, base1, param, ik).
    logic [CL-1:0] m_line [64][4];
    int            m_n = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] v;
        for (int i = 0; i < CL / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [7:0] exp_base(input int r, input int pos);
        logic [CL-1:0] ln;
        if (r >= m_n || pos >= RL) return 8'hFF;
        ln = m_line[r][pos / (CL / 8)];
        return {6'b0, ln[8 * (pos % (CL / 8)) +: 2]};
    endfunction

    task automatic check_reset_outputs();
        chk("rst_load_ready", 64'(load_ready), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_read_valid", 64'(new_read_valid), 64'd0);
        chk("rst_read_num", 64'(new_read_num), 64'h3f);
        chk("rst_query", 64'(new_read_query), 64'hff);
        chk("rst_query_valid", 64'(new_read_query_valid), 64'd0);
        chk("rst_query_tag", 64'(new_read_query_tag), 64'd0);
    endtask

    task automatic check_read_fields(input int r);
        logic [CL-1:0] ik, pm;
        ik = m_line[r][3];
        pm = m_line[r][2];
        chk("ik_x0", new_ik_x0, {31'b0, ik[32:0]});
        chk("ik_x1", new_ik_x1, {31'b0, ik[96:64]});
        chk("ik_x2", new_ik_x2, {31'b0, ik[160:128]});
        chk("ik_info", new_ik_info, {25'b0, ik[230:224], 25'b0, ik[198:192]});
        chk("forward_i", 64'(new_forward_i), 64'(pm[6:0]));
        chk("min_intv", 64'(new_min_intv), 64'(pm[70:64]));
    endtask

    task automatic start_batch(input int sz);
        @(negedge clk);
        batch_start = 1'b1;
        batch_size  = 7'(sz);
        @(negedge clk);
        batch_start = 1'b0;
        m_n = (sz > 64) ? 64 : sz;
    endtask

    task automatic load_reads(input int n, input bit fe);
        bit last;
        for (int r = 0; r < n; r++)
            for (int b = 0; b < 4; b++) m_line[r][b] = rand_line();
        if (fe) m_line[1][0][47:40] = 8'hFE;
        for (int r = 0; r < n; r++) begin
            for (int b = 0; b < 4; b++) begin
                last = (r == n - 1) && (b == 3);
                repeat ($urandom_range(0, 2)) begin
                    load_valid = 1'b0;
                    @(negedge clk);
                end
                if (r == 0 && b == 0) chk("load_ready_in_load", 64'(load_ready), 64'd1);
                if (last) chk("load_done_early", 64'(load_done), 64'd0);
                load_valid = 1'b1;
                load_data  = m_line[r][b];
                @(posedge clk);
                #1;
                if (last) begin
                    chk("load_done_after_last", 64'(load_done), 64'd1);
                    chk("load_ready_after_last", 64'(load_ready), 64'd0);
                end
                @(negedge clk);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic query(input int rn, input int pos, input logic [5:0] tag, input int stalls);
        logic [7:0] exp;
        exp = exp_base(rn, pos);
        stall = 1'b0;
        @(negedge clk);
        query_valid    = 1'b1;
        query_read_num = NW'(rn);
        query_position = POS_W'(pos);
        query_tag      = tag;
        @(negedge clk);
        query_valid = 1'b0;
        stall = (stalls > 0);
        repeat (stalls) @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("query_latency", 64'(new_read_query_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("query_valid", 64'(new_read_query_valid), 64'd1);
        chk("query_data", 64'(new_read_query), 64'(exp));
        chk("query_tag", 64'(new_read_query_tag), 64'(tag));
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2 check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Three-read batch with gapped beats.
        start_batch(3);
        load_reads(3, 1'b1);
        chk("primary", primary, m_line[0][2][191:128]);
        chk("l2_0", L2_0, m_line[0][3][319:256]);
        chk("l2_1", L2_1, m_line[0][3][383:320]);
        chk("l2_2", L2_2, m_line[0][3][447:384]);
        chk("l2_3", L2_3, m_line[0][3][511:448]);

        // A beat outside LOAD must not land anywhere.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = rand_line();
        @(negedge clk);
        load_valid = 1'b0;
        chk("load_done_hold", 64'(load_done), 64'd1);
        chk("load_ready_hold", 64'(load_ready), 64'd0);

        query(1, 5, 6'h05, 0);
        chk("query_fe_byte", 64'(new_read_query), 64'h02);
        query(3, 5, 6'h11, 0);
        for (int i = 0; i < 12; i++)
            query($urandom_range(0, 3), $urandom_range(0, RL - 1), 6'($urandom), 0);
        query(2, $urandom_range(0, RL - 1), 6'h2a, 2);
        query(0, 0, 6'h01, 0);
        query(2, RL - 1, 6'h3f, 0);

        // Issue with stall toggling.
        begin
            int ptr = 0;
            bit ev;
            new_read_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                stall = (i % 2 == 1);
                ev = (ptr < m_n);
                chk("issue_valid", 64'(new_read_valid), 64'(ev));
                chk("issue_num", 64'(new_read_num), ev ? 64'(ptr) : 64'h3f);
                if (ev) check_read_fields(ptr);
                if (ev && !stall) ptr++;
            end
            stall = 1'b0;
            new_read_ready = 1'b0;
        end

        // Oversized batch clamps to 64 reads.
        start_batch(100);
        load_reads(64, 1'b0);
        for (int i = 0; i < 3; i++) query(63, $urandom_range(0, RL - 1), 6'($urandom), 0);
        query(62, $urandom_range(0, RL - 1), 6'h07, 0);
        new_read_ready = 1'b1;
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            chk("max_valid", 64'(new_read_valid), 64'(i < 64));
            if (i < 64) chk("max_num", 64'(new_read_num), 64'(i));
        end
        new_read_ready = 1'b0;

        // Restart mid-LOAD, then an empty batch.
        start_batch(2);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = rand_line();
            @(negedge clk);
        end
        load_valid = 1'b0;
        start_batch(0);
        chk("empty_load_done", 64'(load_done), 64'd1);
        chk("empty_load_ready", 64'(load_ready), 64'd0);
        new_read_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("empty_valid", 64'(new_read_valid), 64'd0);
            chk("empty_num", 64'(new_read_num), 64'h3f);
        end
        query(0, 10, 6'h0c, 0);

        // Asynchronous reset in the middle of SERVE.
        new_read_ready = 1'b0;
        start_batch(2);
        load_reads(2, 1'b0);
        new_read_ready = 1'b1;
        @(negedge clk);
        chk("serve_valid", 64'(new_read_valid), 64'd1);
        chk("serve_num", 64'(new_read_num), 64'd1);
        query_valid    = 1'b1;
        query_read_num = '0;
        query_position = POS_W'(3);
        query_tag      = 6'h15;
        @(negedge clk);
        query_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        new_read_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, tests %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
